// File: rtl/program_sequencer_pkg.sv
// Shared types and default widths for the program sequencer.
package program_sequencer_pkg;

  localparam int INSTR_BIT_DEF   = 8;
  localparam int STACK_DEPTH_DEF = 4;
  localparam int LOOP_BIT_DEF    = 8;

  // Control opcodes from the decoder; encoding 3'd7 behaves as OP_SEQ.
  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_LOOP   = 3'd5,
    OP_END    = 3'd6
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Decoder-side bundle of the program sequencer: instruction controls in, sequencing status out.
interface program_sequencer_if
  import program_sequencer_pkg::*;
#(
  parameter int INSTR_BIT = INSTR_BIT_DEF,
  parameter int LOOP_BIT  = LOOP_BIT_DEF
) ();

  logic                 St;
  logic                 stall;
  logic [2:0]           op;
  logic                 cond;
  logic [INSTR_BIT-1:0] target;
  logic [LOOP_BIT-1:0]  loop_cnt;
  logic [INSTR_BIT-1:0] pc;
  logic                 commit;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output St, stall, op, cond, target, loop_cnt,
    input  pc, commit, busy, done, err
  );

  modport slave (
    input  St, stall, op, cond, target, loop_cnt,
    output pc, commit, busy, done, err
  );

endinterface

// File: rtl/program_sequencer_call_stack.sv
// LIFO of return addresses with synchronous clear; push is ignored when full, pop when empty.
module call_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0]   r_sp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SPW-1:0]   w_spDec;

  assign w_spDec = r_sp - SPW'(1);
  assign o_full  = (r_sp == SPW'(DEPTH));
  assign o_empty = (r_sp == '0);
  assign o_top   = o_empty ? '0 : r_mem[w_spDec[IW-1:0]];

  // Stack pointer: clear wins, otherwise a legal push or pop moves it by one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp <= '0;
    end else if (i_clear) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + SPW'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= w_spDec;
    end
  end

  // Entry storage; contents above the pointer are don't-care, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full && !i_clear) begin
      r_mem[r_sp[IW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: pc generation with jump/branch, call/return stack and one hardware loop level.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int INSTR_BIT   = INSTR_BIT_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int LOOP_BIT    = LOOP_BIT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  program_sequencer_if.slave bus
);

  seq_state_t           r_state, w_stateNext;
  logic [INSTR_BIT-1:0] r_pc, w_pcNext, w_pcInc;
  logic                 r_loopActive, w_loopActiveNext;
  logic [LOOP_BIT-1:0]  r_loopCnt, w_loopCntNext;
  logic                 w_push, w_pop, w_clear;
  logic                 w_full, w_empty;
  logic [INSTR_BIT-1:0] w_top;

  assign w_pcInc = r_pc + INSTR_BIT'(1);

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (INSTR_BIT)
  ) u_stack (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pcInc),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state, next-pc, loop and stack control; every (re)entry to RUN starts from a clean slate.
  always_comb begin
    w_stateNext      = r_state;
    w_pcNext         = r_pc;
    w_loopActiveNext = r_loopActive;
    w_loopCntNext    = r_loopCnt;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_clear          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pcNext = '0;
        if (bus.St) begin
          w_stateNext      = ST_RUN;
          w_clear          = 1'b1;
          w_loopActiveNext = 1'b0;
          w_loopCntNext    = '0;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          case (bus.op)
            OP_JUMP:   w_pcNext = bus.target;
            OP_BRANCH: w_pcNext = bus.cond ? bus.target : w_pcInc;
            OP_CALL: begin
              if (w_full) begin
                w_stateNext = ST_ERR;
              end else begin
                w_push   = 1'b1;
                w_pcNext = bus.target;
              end
            end
            OP_RET: begin
              if (w_empty) begin
                w_stateNext = ST_ERR;
              end else begin
                w_pop    = 1'b1;
                w_pcNext = w_top;
              end
            end
            OP_LOOP: begin
              if (!r_loopActive) begin
                if (bus.loop_cnt == '0) begin
                  w_pcNext = w_pcInc;
                end else begin
                  w_loopActiveNext = 1'b1;
                  w_loopCntNext    = bus.loop_cnt - LOOP_BIT'(1);
                  w_pcNext         = bus.target;
                end
              end else if (r_loopCnt == '0) begin
                w_loopActiveNext = 1'b0;
                w_pcNext         = w_pcInc;
              end else begin
                w_loopCntNext = r_loopCnt - LOOP_BIT'(1);
                w_pcNext      = bus.target;
              end
            end
            OP_END:  w_stateNext = ST_DONE;
            default: w_pcNext = w_pcInc;
          endcase
        end
      end
      ST_DONE: begin
        w_stateNext      = ST_IDLE;
        w_pcNext         = '0;
        w_clear          = 1'b1;
        w_loopActiveNext = 1'b0;
        w_loopCntNext    = '0;
      end
      ST_ERR: begin
        if (bus.St) begin
          w_stateNext      = ST_RUN;
          w_pcNext         = '0;
          w_clear          = 1'b1;
          w_loopActiveNext = 1'b0;
          w_loopCntNext    = '0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_pcNext    = '0;
      end
    endcase
  end

  // Sequencer state registers; reset aborts any run immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_loopActive <= 1'b0;
      r_loopCnt    <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_pc         <= w_pcNext;
      r_loopActive <= w_loopActiveNext;
      r_loopCnt    <= w_loopCntNext;
    end
  end

  assign bus.pc     = r_pc;
  assign bus.busy   = (r_state == ST_RUN);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.err    = (r_state == ST_ERR);
  assign bus.commit = (r_state == ST_RUN) && !bus.stall && (bus.op != OP_END);

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized and directed checking of program_sequencer against a queue-based reference model.
module tb_program_sequencer;

  localparam int IB = 8;
  localparam int SD = 2;
  localparam int LB = 8;
  localparam int NPC = 256;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  localparam logic [2:0] C_SEQ    = 3'd0;
  localparam logic [2:0] C_JUMP   = 3'd1;
  localparam logic [2:0] C_BRANCH = 3'd2;
  localparam logic [2:0] C_CALL   = 3'd3;
  localparam logic [2:0] C_RET    = 3'd4;
  localparam logic [2:0] C_LOOP   = 3'd5;
  localparam logic [2:0] C_END    = 3'd6;
  localparam logic [2:0] C_SPARE  = 3'd7;

  logic CLK = 1'b0;
  logic RST;

  program_sequencer_if #(.INSTR_BIT(IB), .LOOP_BIT(LB)) bus ();

  program_sequencer #(
    .INSTR_BIT   (IB),
    .STACK_DEPTH (SD),
    .LOOP_BIT    (LB)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int nVectors = 0;
  int nMiscompares = 0;

  int mState;
  int mPc;
  int mStack[$];
  bit mLoopActive;
  int mLoopRem;

  bit         sSt, sStall, sCond;
  logic [2:0] sOp;
  int         sTarget, sCnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("pc", 32'(bus.pc), 32'(mPc));
    checkOutput("busy", 32'(bus.busy), 32'(mState == M_RUN));
    checkOutput("done", 32'(bus.done), 32'(mState == M_DONE));
    checkOutput("err", 32'(bus.err), 32'(mState == M_ERR));
    checkOutput("commit", 32'(bus.commit), 32'(mState == M_RUN && !sStall && sOp != C_END));
  endtask

  task automatic modelClear(input int st);
    mState = st;
    mPc = 0;
    mStack.delete();
    mLoopActive = 1'b0;
    mLoopRem = 0;
  endtask

  task automatic modelStep();
    int nxt;
    nxt = (mPc + 1) % NPC;
    case (mState)
      M_IDLE: if (sSt) modelClear(M_RUN);
      M_RUN: begin
        if (!sStall) begin
          case (sOp)
            C_JUMP:   mPc = sTarget;
            C_BRANCH: mPc = sCond ? sTarget : nxt;
            C_CALL: begin
              if (mStack.size() == SD) mState = M_ERR;
              else begin
                mStack.push_back(nxt);
                mPc = sTarget;
              end
            end
            C_RET: begin
              if (mStack.size() == 0) mState = M_ERR;
              else mPc = mStack.pop_back();
            end
            C_LOOP: begin
              if (!mLoopActive) begin
                if (sCnt == 0) mPc = nxt;
                else begin
                  mLoopActive = 1'b1;
                  mLoopRem = sCnt - 1;
                  mPc = sTarget;
                end
              end else if (mLoopRem == 0) begin
                mLoopActive = 1'b0;
                mPc = nxt;
              end else begin
                mLoopRem--;
                mPc = sTarget;
              end
            end
            C_END:   mState = M_DONE;
            default: mPc = nxt;
          endcase
        end
      end
      M_DONE: modelClear(M_IDLE);
      M_ERR: if (sSt) modelClear(M_RUN);
      default: modelClear(M_IDLE);
    endcase
  endtask

  task automatic applyStimulus(input bit st, input bit stall, input logic [2:0] op,
                               input bit cond, input int target, input int cnt);
    sSt = st; sStall = stall; sOp = op; sCond = cond; sTarget = target; sCnt = cnt;
    bus.St = st;
    bus.stall = stall;
    bus.op = op;
    bus.cond = cond;
    bus.target = IB'(target);
    bus.loop_cnt = LB'(cnt);
    #1;
    checkAll();
    @(posedge CLK);
    modelStep();
    @(negedge CLK);
  endtask

  task automatic stepOp(input logic [2:0] op, input int target, input int cnt);
    applyStimulus(1'b0, 1'b0, op, 1'b0, target, cnt);
  endtask

  task automatic asyncReset();
    #2 RST = 1'b0;
    #1;
    checkOutput("rstPc", 32'(bus.pc), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstDone", 32'(bus.done), 32'd0);
    checkOutput("rstErr", 32'(bus.err), 32'd0);
    checkOutput("rstCommit", 32'(bus.commit), 32'd0);
    modelClear(M_IDLE);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    int visits3;
    int r;
    logic [2:0] rop;
    RST = 1'b1;
    bus.St = 1'b0; bus.stall = 1'b0; bus.op = C_SEQ; bus.cond = 1'b0;
    bus.target = '0; bus.loop_cnt = '0;
    sSt = 0; sStall = 0; sOp = C_SEQ; sCond = 0; sTarget = 0; sCnt = 0;
    modelClear(M_IDLE);
    #1 RST = 1'b0;
    @(negedge CLK);
    #1 checkAll();
    @(negedge CLK);
    RST = 1'b1;

    // Stall in IDLE is ignored; then straight-line program ending in END
    applyStimulus(1'b0, 1'b1, C_JUMP, 1'b0, 9, 0);
    applyStimulus(1'b1, 1'b0, C_SEQ, 1'b0, 0, 0);
    stepOp(C_SEQ, 0, 0);
    stepOp(C_SEQ, 0, 0);
    stepOp(C_SEQ, 0, 0);
    stepOp(C_END, 0, 0);
    #1 checkOutput("donePulse", 32'(bus.done), 32'd1);
    applyStimulus(1'b1, 1'b0, C_SEQ, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, C_SEQ, 1'b0, 0, 0);

    // Call and return, then a return with an empty stack faults
    applyStimulus(1'b1, 1'b0, C_SEQ, 1'b0, 0, 0);
    stepOp(C_SEQ, 0, 0);
    stepOp(C_SEQ, 0, 0);
    stepOp(C_CALL, 10, 0);
    stepOp(C_RET, 0, 0);
    #1 checkOutput("retPc", 32'(bus.pc), 32'd3);
    stepOp(C_RET, 0, 0);
    #1 checkOutput("retEmptyErr", 32'(bus.err), 32'd1);
    applyStimulus(1'b1, 1'b0, C_SEQ, 1'b0, 0, 0);

    // Overflowing a two-entry stack freezes pc in ERR until St
    stepOp(C_CALL, 20, 0);
    stepOp(C_CALL, 30, 0);
    stepOp(C_CALL, 40, 0);
    for (int i = 0; i < 3; i++) stepOp(C_JUMP, 50, 0);
    #1 checkOutput("ovfPcFrozen", 32'(bus.pc), 32'd30);
    applyStimulus(1'b1, 1'b0, C_SEQ, 1'b0, 0, 0);
    #1 checkOutput("ovfRecoverErr", 32'(bus.err), 32'd0);

    // Hardware loop over 3..5 with two extra repetitions
    stepOp(C_JUMP, 3, 0);
    visits3 = 0;
    for (int i = 0; i < 30 && mPc != 6; i++) begin
      if (bus.pc == IB'(3)) visits3++;
      stepOp((mPc == 5) ? C_LOOP : C_SEQ, 3, 2);
    end
    checkOutput("loopBodyCount", 32'(visits3), 32'd3);
    checkOutput("loopExitPc", 32'(bus.pc), 32'd6);

    // Stall holds pc and blocks commit, then reset aborts the run
    stepOp(C_JUMP, 7, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, C_JUMP, 1'b1, 99, 0);
      checkOutput("stallPc", 32'(bus.pc), 32'd7);
    end
    stepOp(C_SEQ, 0, 0);
    asyncReset();
    applyStimulus(1'b0, 1'b0, C_SEQ, 1'b0, 0, 0);

    // pc wrap at the top of program space, including a CALL pushing address 0
    applyStimulus(1'b1, 1'b0, C_SEQ, 1'b0, 0, 0);
    stepOp(C_JUMP, 255, 0);
    stepOp(C_SEQ, 0, 0);
    #1 checkOutput("wrapSeq", 32'(bus.pc), 32'd0);
    stepOp(C_JUMP, 255, 0);
    stepOp(C_CALL, 9, 0);
    stepOp(C_RET, 0, 0);
    #1 checkOutput("wrapCallRet", 32'(bus.pc), 32'd0);
    stepOp(C_LOOP, 40, 0);
    stepOp(C_END, 0, 0);
    stepOp(C_SEQ, 0, 0);

    // Random instruction streams, stalls and occasional asynchronous resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        asyncReset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 35) rop = C_SEQ;
        else if (r < 45) rop = C_JUMP;
        else if (r < 57) rop = C_BRANCH;
        else if (r < 68) rop = C_CALL;
        else if (r < 79) rop = C_RET;
        else if (r < 91) rop = C_LOOP;
        else if (r < 94) rop = C_END;
        else rop = C_SPARE;
        applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), rop,
                      $urandom_range(0, 1) == 1, $urandom_range(0, NPC - 1),
                      $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter INSTR_BIT, default `INSTR_BIT: program-counter width; program space is 2**INSTR_BIT words.
REQ-002 SHALL have parameter STACK_DEPTH, default 4: call/return stack entries, minimum 1.
REQ-003 SHALL have parameter LOOP_BIT, default 8: hardware loop counter width.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port St, input, 1, start request.
REQ-007 SHALL have port stall, input, 1, datapath busy; freezes sequencing.
REQ-008 SHALL have port op, input, 3, control opcode of the current instruction from decoder: SEQ, JUMP, BRANCH, CALL, RET, LOOP, END; the eighth encoding is treated as SEQ.
REQ-009 SHALL have port cond, input, 1, branch condition for BRANCH.
REQ-010 SHALL have port target, input, INSTR_BIT, jump/branch/call/loop-start address.
REQ-011 SHALL have port loop_cnt, input, LOOP_BIT, extra repetitions requested by LOOP.
REQ-012 SHALL have port pc, output, INSTR_BIT, address of the current instruction.
REQ-013 SHALL have port commit, output, 1, current instruction may write data memory.
REQ-014 SHALL have port busy, output, 1, high in RUN.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1, sticky stack fault flag.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE, ERR.
REQ-018 IDLE: pc held at 0; St=1 -> RUN next edge with pc=0; stall ignored in IDLE.
REQ-019 RUN, stall=1: pc, stack, loop state and FSM SHALL hold; commit=0.
REQ-020 RUN, stall=0: SEQ -> pc+1; JUMP -> target; BRANCH -> target if cond else pc+1.
REQ-021 CALL: push pc+1, pc <= target; if stack full -> ERR, no push, err=1.
REQ-022 RET: pop into pc; if stack empty -> ERR, err=1.
REQ-023 LOOP, no loop active: loop_cnt=0 -> pc+1; else load counter with loop_cnt-1, set loop active, pc <= target.
REQ-024 LOOP, loop active: counter=0 -> clear active, pc+1; else decrement, pc <= target; body thus runs loop_cnt+1 times total.
REQ-025 Only one hardware loop level; a LOOP at a different address while active SHALL be treated as the same active loop.
REQ-026 END -> DONE; done=1 for exactly that DONE cycle, then IDLE with pc=0; stack and loop state cleared.
REQ-027 pc+1 SHALL wrap modulo 2**INSTR_BIT (max address -> 0); a CALL from max address pushes 0.
REQ-028 commit = (state==RUN) & ~stall & (op!=END); combinational from state and inputs.
REQ-029 busy = (state==RUN); done and busy never both high.
REQ-030 St while RUN or DONE SHALL be ignored.
REQ-031 ERR: pc frozen, commit=0, err=1; St=1 -> RUN, pc=0, err cleared, stack and loop cleared.

Reset
REQ-032 RST=0 SHALL asynchronously force IDLE, pc=0, commit=0, busy=0, done=0, err=0, stack pointer 0, loop inactive, counter 0.
REQ-033 Reset asserted mid-RUN SHALL abort without a done pulse; release returns to IDLE.

Structure
REQ-034 Shared package SHALL hold opcode enum seq_op_t, state enum seq_state_t and the default widths.
REQ-035 Call stack SHALL be sub-module call_stack (LIFO; push, pop, full, empty, top; async active-low reset).

Verification
REQ-036 St pulse, op=SEQ x3 then END -> pc 0,1,2,3; done high one cycle after END; busy then 0.
REQ-037 At pc=2, CALL target=10; at 10 RET -> pc 10 then 3; stack empty afterwards.
REQ-038 STACK_DEPTH=2, three nested CALLs -> err=1, state ERR, pc frozen; St -> pc=0, err=0.
REQ-039 LOOP at pc=5, target=3, loop_cnt=2 -> body 3..5 executes 3 times, then pc=6.
REQ-040 stall held 4 cycles at pc=7 -> pc stays 7, commit=0; RST low mid-run -> all outputs 0 immediately, no done.
